// File: rtl/lsu_if.sv
// Bundle of the LSU request, memory and register-file write channels.
// The slave modport is the LSU itself; master is the surrounding pipeline/memory.
interface lsu_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_is_load;
    logic [2:0]            req_funct3;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [ADDR_WIDTH-1:0] req_rd;

    logic                  mem_valid;
    logic                  mem_ready;
    logic                  mem_wen;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_wmask;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic                  done;
    logic                  err;

    modport master (
        output req_valid, req_is_load, req_funct3, req_addr, req_wdata, req_rd,
        output mem_ready, mem_rvalid, mem_rdata,
        input  req_ready, mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        input  rf_wen, rf_waddr, rf_wdata, done, err
    );

    modport slave (
        input  req_valid, req_is_load, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_ready, mem_rvalid, mem_rdata,
        output req_ready, mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        output rf_wen, rf_waddr, rf_wdata, done, err
    );
endinterface

// File: rtl/lsu.sv
// RV32 load/store unit: one outstanding op, byte/half/word accesses with
// lane steering on stores and sign/zero extraction on loads.
module lsu #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    lsu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MREQ, MWAIT, WB} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_is_load;
    logic [2:0]            r_funct3;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_ldata;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_reject;
    logic                  w_f3_ok;
    logic [DATA_WIDTH-1:0] w_shift;
    logic [DATA_WIDTH-1:0] w_ext;
    logic [DATA_WIDTH-1:0] w_st_data;
    logic [3:0]            w_st_mask;

    // funct3[1:0] encodes access size for every legal load and store
    always_comb begin
        w_f3_ok = 1'b0;
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
            3'b100, 3'b101:         w_f3_ok = bus.req_is_load;
            default:                w_f3_ok = 1'b0;
        endcase
        w_reject = !w_f3_ok
            || (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
            || (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
    end

    always_comb begin
        w_shift = bus.mem_rdata >> {r_addr[1:0], 3'b000};
        case (r_funct3)
            3'b000:  w_ext = {{(DATA_WIDTH-8){w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_ext = {{(DATA_WIDTH-16){w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_ext = {{(DATA_WIDTH-8){1'b0}}, w_shift[7:0]};
            3'b101:  w_ext = {{(DATA_WIDTH-16){1'b0}}, w_shift[15:0]};
            default: w_ext = w_shift;
        endcase
    end

    always_comb begin
        w_st_mask = '0;
        w_st_data = '0;
        if (!r_is_load) begin
            case (r_funct3[1:0])
                2'b00: begin
                    w_st_mask = 4'b0001 << r_addr[1:0];
                    w_st_data = {4{r_wdata[7:0]}};
                end
                2'b01: begin
                    w_st_mask = 4'b0011 << r_addr[1:0];
                    w_st_data = {2{r_wdata[15:0]}};
                end
                default: begin
                    w_st_mask = 4'b1111;
                    w_st_data = r_wdata;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Outputs are forced to zero while rst is high, independent of the state register
    always_comb begin
        w_next        = r_state;
        w_accept      = 1'b0;
        bus.req_ready = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_wen   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wmask = '0;
        bus.rf_wen    = 1'b0;
        bus.rf_waddr  = '0;
        bus.rf_wdata  = '0;
        bus.done      = 1'b0;
        bus.err       = 1'b0;
        if (!rst) begin
            bus.err = r_err;
            case (r_state)
                IDLE: begin
                    bus.req_ready = 1'b1;
                    if (bus.req_valid) begin
                        w_accept = 1'b1;
                        if (!w_reject) w_next = MREQ;
                    end
                end
                MREQ: begin
                    bus.mem_valid = 1'b1;
                    bus.mem_wen   = !r_is_load;
                    bus.mem_addr  = {r_addr[DATA_WIDTH-1:2], 2'b00};
                    bus.mem_wdata = w_st_data;
                    bus.mem_wmask = w_st_mask;
                    if (bus.mem_ready) w_next = r_is_load ? MWAIT : WB;
                end
                MWAIT: begin
                    if (bus.mem_rvalid) w_next = WB;
                end
                WB: begin
                    bus.done = 1'b1;
                    if (r_is_load && r_rd != '0) begin
                        bus.rf_wen   = 1'b1;
                        bus.rf_waddr = r_rd;
                        bus.rf_wdata = r_ldata;
                    end
                    w_next = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_load <= 1'b0;
            r_funct3  <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rd      <= '0;
            r_ldata   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_accept && w_reject;
            if (w_accept) begin
                r_is_load <= bus.req_is_load;
                r_funct3  <= bus.req_funct3;
                r_addr    <= bus.req_addr;
                r_wdata   <= bus.req_wdata;
                r_rd      <= bus.req_rd;
            end
            if (r_state == MWAIT && bus.mem_rvalid) r_ldata <= w_ext;
        end
    end
endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vectors plus randomized ops scored
// against an arithmetic reference model of the load/store rules.
module tb_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();
    lsu #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        acc_ready;
        int          memv_first;
        int          memv_cnt;
        int          hs;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [3:0]  wmask;
        logic        mwen;
        logic        stable;
        int          done_c;
        int          err_c;
        logic        err_ready;
        int          rfwen_cnt;
        logic [3:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic        overlap;
    } obs_t;

    function automatic bit mdl_reject(input bit ld, input int f3, input longint unsigned addr);
        bit legal;
        longint unsigned size;
        if (ld) legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        else    legal = (f3 <= 2);
        if (!legal) return 1'b1;
        size = 64'd1 << (f3 % 4);
        return (addr % size) != 0;
    endfunction

    function automatic logic [31:0] mdl_load(input int f3, input longint unsigned addr,
                                             input longint unsigned rdata);
        longint unsigned size, v;
        size = 64'd1 << (f3 % 4);
        v = (rdata >> (8 * (addr % 4))) % (64'd1 << (8 * size));
        if (f3 < 4 && size < 4 && v >= (64'd1 << (8 * size - 1)))
            v = v + 64'h1_0000_0000 - (64'd1 << (8 * size));
        return v[31:0];
    endfunction

    function automatic logic [3:0] mdl_mask(input int f3, input longint unsigned addr);
        logic [3:0] m;
        int off, size;
        off  = int'(addr % 4);
        size = 1 << (f3 % 4);
        for (int i = 0; i < 4; i++) m[i] = (i >= off) && (i < off + size);
        return m;
    endfunction

    function automatic logic [31:0] mdl_sdata(input int f3, input logic [31:0] wdata);
        logic [31:0] d;
        int size;
        size = 1 << (f3 % 4);
        for (int i = 0; i < 4; i++) d[8*i +: 8] = wdata[8*(i % size) +: 8];
        return d;
    endfunction

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Offers one op, then plays memory with the given ready/rvalid delays and
    // records what the LSU did until it retires or rejects (bounded to 40 cycles).
    task automatic drive_op(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] rd,
                            input logic [31:0] rdata, input int rdy, input int rv,
                            output obs_t ob);
        int rv_at;
        ob.acc_ready = 1'b0; ob.memv_first = -1; ob.memv_cnt = 0; ob.hs = -1;
        ob.maddr = '0; ob.mwdata = '0; ob.wmask = '0; ob.mwen = 1'b0; ob.stable = 1'b1;
        ob.done_c = -1; ob.err_c = -1; ob.err_ready = 1'b0; ob.rfwen_cnt = 0;
        ob.rf_waddr = '0; ob.rf_wdata = '0; ob.overlap = 1'b0;
        rv_at = -1;
        next_cycle();
        bus.req_valid = 1'b1; bus.req_is_load = ld; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wdata; bus.req_rd = rd;
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
        #1 ob.acc_ready = bus.req_ready;
        for (int c = 1; c <= 40; c++) begin
            next_cycle();
            bus.req_valid = 1'b0;
            bus.req_is_load = 1'($urandom); bus.req_funct3 = 3'($urandom);
            bus.req_addr = $urandom; bus.req_wdata = $urandom; bus.req_rd = 4'($urandom);
            bus.mem_ready = 1'b0;
            if (bus.mem_valid) begin
                if (ob.memv_first < 0) begin
                    ob.memv_first = c; ob.maddr = bus.mem_addr; ob.mwdata = bus.mem_wdata;
                    ob.wmask = bus.mem_wmask; ob.mwen = bus.mem_wen;
                end else if (bus.mem_addr !== ob.maddr || bus.mem_wdata !== ob.mwdata ||
                             bus.mem_wmask !== ob.wmask || bus.mem_wen !== ob.mwen) begin
                    ob.stable = 1'b0;
                end
                ob.memv_cnt++;
                if (ob.hs < 0 && c - ob.memv_first >= rdy) begin
                    bus.mem_ready = 1'b1; ob.hs = c; rv_at = c + 1 + rv;
                end
            end
            if (c == rv_at) begin
                bus.mem_rvalid = 1'b1; bus.mem_rdata = rdata;
            end else if (ob.hs >= 0 && c > ob.hs) begin
                bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
            end else begin
                bus.mem_rvalid = 1'($urandom); bus.mem_rdata = $urandom;
            end
            #1;
            if (bus.err && ob.err_c < 0) begin
                ob.err_c = c; ob.err_ready = bus.req_ready;
            end
            if (bus.rf_wen) ob.rfwen_cnt++;
            if (bus.err && (bus.done || bus.rf_wen)) ob.overlap = 1'b1;
            if (bus.done) begin
                ob.done_c = c; ob.rf_waddr = bus.rf_waddr; ob.rf_wdata = bus.rf_wdata;
            end
            if (ob.done_c >= 0 || ob.err_c >= 0) break;
        end
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;
    endtask

    task automatic test_load(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [3:0] rd, input logic [31:0] rdata,
                             input int rdy, input int rv);
        obs_t ob;
        logic [31:0] exp;
        drive_op(1'b1, f3, addr, $urandom, rd, rdata, rdy, rv, ob);
        exp = mdl_load(int'(f3), addr, rdata);
        checks++; if (ob.acc_ready !== 1'b1) begin errors++; $display("FAIL %s req_ready: got %b expected 1", nm, ob.acc_ready); end
        checks++; if (ob.memv_cnt !== rdy + 1) begin errors++; $display("FAIL %s mem_valid cycles: got %0d expected %0d", nm, ob.memv_cnt, rdy + 1); end
        checks++; if (ob.maddr !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL %s mem_addr: got %h expected %h", nm, ob.maddr, {addr[31:2], 2'b00}); end
        checks++; if ({ob.mwen, ob.wmask} !== 5'b0) begin errors++; $display("FAIL %s load wen/wmask: got %b expected 00000", nm, {ob.mwen, ob.wmask}); end
        checks++; if (ob.stable !== 1'b1) begin errors++; $display("FAIL %s mem stable: got %b expected 1", nm, ob.stable); end
        checks++; if (ob.done_c !== 3 + rdy + rv) begin errors++; $display("FAIL %s done cycle: got %0d expected %0d", nm, ob.done_c, 3 + rdy + rv); end
        checks++; if (ob.rfwen_cnt !== int'(rd != 0)) begin errors++; $display("FAIL %s rf_wen count: got %0d expected %0d", nm, ob.rfwen_cnt, int'(rd != 0)); end
        checks++; if (ob.err_c !== -1) begin errors++; $display("FAIL %s err: got cycle %0d expected none", nm, ob.err_c); end
        if (rd != 0) begin
            checks++; if (ob.rf_waddr !== rd) begin errors++; $display("FAIL %s rf_waddr: got %0d expected %0d", nm, ob.rf_waddr, rd); end
            checks++; if (ob.rf_wdata !== exp) begin errors++; $display("FAIL %s rf_wdata: got %h expected %h", nm, ob.rf_wdata, exp); end
        end
    endtask

    task automatic test_store(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input int rdy);
        obs_t ob;
        drive_op(1'b0, f3, addr, wdata, 4'($urandom), $urandom, rdy, 0, ob);
        checks++; if (ob.acc_ready !== 1'b1) begin errors++; $display("FAIL %s req_ready: got %b expected 1", nm, ob.acc_ready); end
        checks++; if (ob.maddr !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL %s mem_addr: got %h expected %h", nm, ob.maddr, {addr[31:2], 2'b00}); end
        checks++; if (ob.mwen !== 1'b1) begin errors++; $display("FAIL %s mem_wen: got %b expected 1", nm, ob.mwen); end
        checks++; if (ob.wmask !== mdl_mask(int'(f3), addr)) begin errors++; $display("FAIL %s wmask: got %b expected %b", nm, ob.wmask, mdl_mask(int'(f3), addr)); end
        checks++; if (ob.mwdata !== mdl_sdata(int'(f3), wdata)) begin errors++; $display("FAIL %s mem_wdata: got %h expected %h", nm, ob.mwdata, mdl_sdata(int'(f3), wdata)); end
        checks++; if (ob.stable !== 1'b1) begin errors++; $display("FAIL %s mem stable: got %b expected 1", nm, ob.stable); end
        checks++; if (ob.done_c !== 2 + rdy) begin errors++; $display("FAIL %s done cycle: got %0d expected %0d", nm, ob.done_c, 2 + rdy); end
        checks++; if (ob.rfwen_cnt !== 0) begin errors++; $display("FAIL %s store rf_wen: got %0d expected 0", nm, ob.rfwen_cnt); end
        checks++; if (ob.err_c !== -1) begin errors++; $display("FAIL %s err: got cycle %0d expected none", nm, ob.err_c); end
    endtask

    task automatic test_reject(input string nm, input logic ld, input logic [2:0] f3,
                               input logic [31:0] addr);
        obs_t ob;
        drive_op(ld, f3, addr, $urandom, 4'($urandom | 1), $urandom, 0, 0, ob);
        checks++; if (ob.err_c !== 1) begin errors++; $display("FAIL %s err cycle: got %0d expected 1", nm, ob.err_c); end
        checks++; if (ob.err_ready !== 1'b1) begin errors++; $display("FAIL %s req_ready at err: got %b expected 1", nm, ob.err_ready); end
        checks++; if (ob.memv_cnt !== 0) begin errors++; $display("FAIL %s mem_valid: got %0d cycles expected 0", nm, ob.memv_cnt); end
        checks++; if (ob.done_c !== -1 || ob.rfwen_cnt !== 0 || ob.overlap !== 1'b0) begin errors++; $display("FAIL %s done/rf_wen with err: got done %0d rf_wen %0d expected none", nm, ob.done_c, ob.rfwen_cnt); end
        next_cycle();
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL %s err width: got %b expected 0", nm, bus.err); end
    endtask

    task automatic check_outputs_zero(input string nm);
        checks++;
        if ({bus.req_ready, bus.mem_valid, bus.mem_wen, bus.mem_wmask, bus.rf_wen, bus.done, bus.err} !== 10'b0 ||
            bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.rf_waddr !== 4'h0 || bus.rf_wdata !== 32'h0) begin
            errors++;
            $display("FAIL %s outputs in reset: got rdy=%b mv=%b wen=%b msk=%b rfw=%b done=%b err=%b addr=%h wd=%h expected all 0",
                     nm, bus.req_ready, bus.mem_valid, bus.mem_wen, bus.mem_wmask, bus.rf_wen, bus.done, bus.err, bus.mem_addr, bus.mem_wdata);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            bus.req_valid = 1'b1; bus.req_is_load = 1'($urandom); bus.req_funct3 = 3'($urandom);
            bus.req_addr = $urandom; bus.req_wdata = $urandom; bus.req_rd = 4'($urandom);
            bus.mem_ready = 1'($urandom); bus.mem_rvalid = 1'($urandom); bus.mem_rdata = $urandom;
            #1 check_outputs_zero("reset");
        end
        next_cycle();
        rst = 1'b0; bus.req_valid = 1'b0; bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL post_reset req_ready: got %b expected 1", bus.req_ready); end
    endtask

    task automatic test_directed;
        test_load("LW_ref", 3'b010, 32'h8000_0004, 4'd10, 32'hDEAD_BEEF, 0, 0);
        test_load("LB_sign", 3'b000, 32'h8000_0003, 4'd7, 32'h80FF_FFFF, 0, 0);
        test_load("LBU_zero", 3'b100, 32'h8000_0003, 4'd7, 32'h80FF_FFFF, 0, 0);
        test_load("LH_hi", 3'b001, 32'h0000_0102, 4'd3, 32'h9ABC_1234, 1, 2);
        test_load("LHU_hi", 3'b101, 32'h0000_0102, 4'd3, 32'h9ABC_1234, 0, 1);
        test_store("SH_ref", 3'b001, 32'h0000_0002, 32'h1234_ABCD, 0);
        test_store("SB_lane1", 3'b000, 32'h0000_0011, 32'h0000_00A5, 2);
        test_store("SW_ref", 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 0);
        test_reject("LW_misal", 1'b1, 3'b010, 32'h0000_0006);
        test_reject("SH_odd", 1'b0, 3'b001, 32'h0000_0001);
        test_reject("S_f3_100", 1'b0, 3'b100, 32'h0000_0000);
        test_reject("L_f3_111", 1'b1, 3'b111, 32'h0000_0000);
        test_load("LW_stall_rd0", 3'b010, 32'h0000_0040, 4'd0, 32'h1111_2222, 5, 0);
    endtask

    task automatic test_back_to_back;
        test_store("b2b_st", 3'b010, 32'h0000_0100, $urandom, 0);
        test_load("b2b_ld", 3'b010, 32'h0000_0100, 4'd1, $urandom, 0, 0);
        test_reject("b2b_rej", 1'b1, 3'b001, 32'h0000_0003);
        test_load("b2b_ld2", 3'b000, 32'h0000_0105, 4'd2, $urandom, 0, 0);
    endtask

    task automatic test_random;
        int f3, size;
        bit ld;
        logic [31:0] addr;
        for (int n = 0; n < 40; n++) begin
            ld = 1'($urandom);
            if ($urandom_range(0, 9) < 8) begin
                f3 = ld ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 2));
                if (ld && f3 == 3) f3 = 5;
            end else begin
                f3 = int'($urandom_range(0, 7));
            end
            addr = $urandom;
            size = 1 << (f3 % 4);
            if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(size) - 32'd1);
            if (mdl_reject(ld, f3, addr))
                test_reject("rnd_rej", ld, 3'(f3), addr);
            else if (ld)
                test_load("rnd_ld", 3'(f3), addr, 4'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
            else
                test_store("rnd_st", 3'(f3), addr, $urandom, $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid;
        next_cycle();
        bus.req_valid = 1'b1; bus.req_is_load = 1'b1; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h0000_0200; bus.req_rd = 4'd5;
        next_cycle();
        bus.req_valid = 1'b0; bus.mem_ready = 1'b1;
        #1;
        checks++; if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL rst_mid mem_valid: got %b expected 1", bus.mem_valid); end
        next_cycle();
        bus.mem_ready = 1'b0; rst = 1'b1;
        #1 check_outputs_zero("rst_mid");
        next_cycle();
        rst = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
        #1;
        checks++; if ({bus.req_ready, bus.done, bus.rf_wen} !== 3'b100) begin errors++; $display("FAIL rst_mid after rst: got rdy/done/rfw=%b expected 100", {bus.req_ready, bus.done, bus.rf_wen}); end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            bus.mem_rvalid = 1'b0;
            #1;
            checks++; if ({bus.done, bus.rf_wen, bus.mem_valid} !== 3'b000) begin errors++; $display("FAIL rst_mid late: got done/rfw/mv=%b expected 000", {bus.done, bus.rf_wen, bus.mem_valid}); end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_is_load = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.req_rd = '0;
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
